// File: rtl/cyq_ssd_pkg.sv
// Shared constants for the multiplexed seven-segment scan controller.
// Glyph order is {a,b,c,d,e,f,g} with a in bit 6.
package cyq_ssd_pkg;

  typedef logic [3:0] nibble_t;
  typedef logic [6:0] glyph_t;

  localparam glyph_t SEG_BLANK  = 7'b000_0000;
  localparam glyph_t SEG_ALL_ON = 7'b111_1111;

  localparam glyph_t SEG_GLYPH [16] = '{
    7'b111_1110,  // 0
    7'b011_0000,  // 1
    7'b110_1101,  // 2
    7'b111_1001,  // 3
    7'b011_0011,  // 4
    7'b101_1011,  // 5
    7'b101_1111,  // 6
    7'b111_0000,  // 7
    7'b111_1111,  // 8
    7'b111_1011,  // 9
    7'b111_0111,  // A
    7'b001_1111,  // b
    7'b100_1110,  // C
    7'b011_1101,  // d
    7'b100_1111,  // E
    7'b100_0111   // F
  };

  function automatic int cyq_clog2(input int n);
    int r;
    r = 0;
    while ((64'd1 << r) < 64'(n)) begin
      r = r + 1;
    end
    return r;
  endfunction

  // Counter width that never collapses to zero bits.
  function automatic int cyq_cnt_width(input int n);
    int w;
    w = cyq_clog2(n);
    if (w < 1) begin
      w = 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/cyq_seg_decode.sv
// Nibble to seven-segment glyph; in BCD mode codes 10..15 render blank.
module cyq_seg_decode
  import cyq_ssd_pkg::*;
(
  input  logic [3:0] val_i,
  input  logic       mode_i,
  output logic [6:0] glyph_o
);

  always_comb begin
    if (mode_i || (val_i < 4'd10)) begin
      glyph_o = SEG_GLYPH[val_i];
    end else begin
      glyph_o = SEG_BLANK;
    end
  end

endmodule

// File: rtl/cyq_ssd_scan_ctrl.sv
// N-digit multiplexed seven-segment scanner with double-buffered digits,
// leading-zero blanking, PWM brightness and lamp test.
module cyq_ssd_scan_ctrl
  import cyq_ssd_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int CLK_DIV  = 50000,
  parameter int PWM_BITS = 3,
  parameter bit COM_ACT  = 1'b0,
  parameter bit SEG_ACT  = 1'b1
) (
  input  logic                       clk_i,
  input  logic                       aclr_i,
  input  logic                       load_i,
  input  logic [4*DIGITS-1:0]        din_i,
  input  logic [DIGITS-1:0]          dp_in_i,
  input  logic                       mode_i,
  input  logic                       lz_blank_i,
  input  logic [PWM_BITS-1:0]        bright_i,
  input  logic                       lt_i,
  output logic [DIGITS-1:0]          com_o,
  output logic [6:0]                 seg_o,
  output logic                       dp_o,
  output logic [$clog2(DIGITS)-1:0]  scan_idx_o,
  output logic                       frame_done_o
);

  localparam int IDX_W   = cyq_clog2(DIGITS);
  localparam int CNT_W   = cyq_cnt_width(CLK_DIV);
  localparam int SUB_LEN = CLK_DIV >> PWM_BITS;
  localparam int SUBC_W  = cyq_cnt_width(SUB_LEN);

  localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(CLK_DIV - 1);
  localparam logic [SUBC_W-1:0] LAST_SUBC = SUBC_W'(SUB_LEN - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(DIGITS - 1);

  localparam logic [DIGITS-1:0] COM_OFF = {DIGITS{~COM_ACT}};
  localparam logic [6:0]        SEG_OFF = {7{~SEG_ACT}};

  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [SUBC_W-1:0]   subc_q, subc_d;
  logic [PWM_BITS-1:0] sub_q, sub_d;
  logic [IDX_W-1:0]    scan_q, scan_d;
  logic                fd_q, fd_d;
  logic                tick;
  logic                frame_end;

  logic [4*DIGITS-1:0] pend_din_q, pend_din_d;
  logic [DIGITS-1:0]   pend_dp_q, pend_dp_d;
  logic                pend_vld_q, pend_vld_d;
  logic [4*DIGITS-1:0] act_din_q, act_din_d;
  logic [DIGITS-1:0]   act_dp_q, act_dp_d;

  logic [3:0]          cur_val;
  logic [6:0]          glyph;
  logic [DIGITS-1:0]   lz_chain;
  logic                lz_hit;
  logic                com_on;
  logic [DIGITS-1:0]   com_val, com_d, com_q;
  logic [6:0]          seg_val, seg_d, seg_q;
  logic                dp_val, dp_d, dp_q;

  // Slot prescaler, PWM sub-slot tracker and digit scan counter.
  // sub_q tracks cnt/SUB_LEN incrementally so no divider is needed.
  always_comb begin
    tick      = (cnt_q == LAST_CNT);
    frame_end = tick && (scan_q == LAST_IDX);
    cnt_d     = cnt_q;
    subc_d    = subc_q;
    sub_d     = sub_q;
    scan_d    = scan_q;
    if (tick) begin
      cnt_d  = '0;
      subc_d = '0;
      sub_d  = '0;
      if (scan_q == LAST_IDX) begin
        scan_d = '0;
      end else begin
        scan_d = scan_q + 1'b1;
      end
    end else begin
      cnt_d = cnt_q + 1'b1;
      if (subc_q == LAST_SUBC) begin
        subc_d = '0;
        sub_d  = sub_q + 1'b1;
      end else begin
        subc_d = subc_q + 1'b1;
        sub_d  = sub_q;
      end
    end
    fd_d = (cnt_d == LAST_CNT) && (scan_d == LAST_IDX);
  end

  // Double buffer: the active copy only changes at a frame boundary.
  always_comb begin
    pend_din_d = pend_din_q;
    pend_dp_d  = pend_dp_q;
    pend_vld_d = pend_vld_q;
    act_din_d  = act_din_q;
    act_dp_d   = act_dp_q;
    if (load_i) begin
      pend_din_d = din_i;
      pend_dp_d  = dp_in_i;
      pend_vld_d = 1'b1;
    end else begin
      pend_vld_d = pend_vld_q;
    end
    if (frame_end) begin
      if (load_i) begin
        act_din_d  = din_i;
        act_dp_d   = dp_in_i;
        pend_vld_d = 1'b0;
      end else if (pend_vld_q) begin
        act_din_d  = pend_din_q;
        act_dp_d   = pend_dp_q;
        pend_vld_d = 1'b0;
      end else begin
        act_din_d = act_din_q;
        act_dp_d  = act_dp_q;
      end
    end else begin
      act_din_d = act_din_q;
      act_dp_d  = act_dp_q;
    end
  end

  // lz_chain[k] is set when digit k and every digit above it are zero.
  always_comb begin
    lz_chain = '0;
    lz_chain[DIGITS-1] = (act_din_q[4*(DIGITS-1) +: 4] == 4'd0);
    for (int k = DIGITS - 2; k >= 0; k--) begin
      lz_chain[k] = lz_chain[k+1] && (act_din_q[4*k +: 4] == 4'd0);
    end
  end

  assign cur_val = act_din_q[{scan_q, 2'b00} +: 4];

  cyq_seg_decode u_decode (
    .val_i   (cur_val),
    .mode_i  (mode_i),
    .glyph_o (glyph)
  );

  // Output image for the digit currently scanned, before active-level mapping.
  always_comb begin
    lz_hit  = lz_blank_i && (scan_q != '0) && lz_chain[scan_q];
    com_on  = lt_i || (sub_q <= bright_i);
    com_val = '0;
    if (com_on) begin
      com_val[scan_q] = 1'b1;
    end else begin
      com_val = '0;
    end
    if (lt_i) begin
      seg_val = SEG_ALL_ON;
      dp_val  = 1'b1;
    end else if (lz_hit) begin
      seg_val = SEG_BLANK;
      dp_val  = act_dp_q[scan_q];
    end else begin
      seg_val = glyph;
      dp_val  = act_dp_q[scan_q];
    end
    com_d = com_val ^ COM_OFF;
    seg_d = seg_val ^ SEG_OFF;
    dp_d  = dp_val ^ ~SEG_ACT;
  end

  // Scan timing and buffer state.
  always_ff @(posedge clk_i) begin
    if (aclr_i) begin
      cnt_q      <= '0;
      subc_q     <= '0;
      sub_q      <= '0;
      scan_q     <= '0;
      fd_q       <= 1'b0;
      pend_din_q <= '0;
      pend_dp_q  <= '0;
      pend_vld_q <= 1'b0;
      act_din_q  <= '0;
      act_dp_q   <= '0;
    end else begin
      cnt_q      <= cnt_d;
      subc_q     <= subc_d;
      sub_q      <= sub_d;
      scan_q     <= scan_d;
      fd_q       <= fd_d;
      pend_din_q <= pend_din_d;
      pend_dp_q  <= pend_dp_d;
      pend_vld_q <= pend_vld_d;
      act_din_q  <= act_din_d;
      act_dp_q   <= act_dp_d;
    end
  end

  // Pin drivers, one cycle behind the scan state.
  always_ff @(posedge clk_i) begin
    if (aclr_i) begin
      com_q <= COM_OFF;
      seg_q <= SEG_OFF;
      dp_q  <= ~SEG_ACT;
    end else begin
      com_q <= com_d;
      seg_q <= seg_d;
      dp_q  <= dp_d;
    end
  end

  assign com_o        = com_q;
  assign seg_o        = seg_q;
  assign dp_o         = dp_q;
  assign scan_idx_o   = scan_q;
  assign frame_done_o = fd_q;

endmodule

// File: tb/tb_cyq_ssd_scan_ctrl.sv
// Directed bench for cyq_ssd_scan_ctrl with DIGITS=4, CLK_DIV=16, PWM_BITS=2.
module tb_cyq_ssd_scan_ctrl;

  localparam int DIGITS   = 4;
  localparam int CLK_DIV  = 16;
  localparam int PWM_BITS = 2;

  localparam logic [6:0] G0 = 7'b1111110;
  localparam logic [6:0] G1 = 7'b0110000;
  localparam logic [6:0] G2 = 7'b1101101;
  localparam logic [6:0] G3 = 7'b1111001;
  localparam logic [6:0] G4 = 7'b0110011;
  localparam logic [6:0] G5 = 7'b1011011;
  localparam logic [6:0] G6 = 7'b1011111;
  localparam logic [6:0] G7 = 7'b1110000;
  localparam logic [6:0] G8 = 7'b1111111;
  localparam logic [6:0] GA = 7'b1110111;
  localparam logic [6:0] GF = 7'b1000111;
  localparam logic [6:0] GX = 7'b0000000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                aclr;
  logic                load;
  logic [15:0]         din;
  logic [3:0]          dp_in;
  logic                mode;
  logic                lz_blank;
  logic [1:0]          bright;
  logic                lt;
  logic [3:0]          com;
  logic [6:0]          seg;
  logic                dp;
  logic [1:0]          scan_idx;
  logic                frame_done;

  cyq_ssd_scan_ctrl #(
    .DIGITS   (DIGITS),
    .CLK_DIV  (CLK_DIV),
    .PWM_BITS (PWM_BITS),
    .COM_ACT  (1'b0),
    .SEG_ACT  (1'b1)
  ) dut (
    .clk_i        (clk),
    .aclr_i       (aclr),
    .load_i       (load),
    .din_i        (din),
    .dp_in_i      (dp_in),
    .mode_i       (mode),
    .lz_blank_i   (lz_blank),
    .bright_i     (bright),
    .lt_i         (lt),
    .com_o        (com),
    .seg_o        (seg),
    .dp_o         (dp),
    .scan_idx_o   (scan_idx),
    .frame_done_o (frame_done)
  );

  int n_checks = 0;
  int n_pass   = 0;

  int         on_cnt  [4];
  logic [6:0] seg_cap [4];
  logic       dp_cap  [4];
  int         bad_com;
  int         bad_fd;
  int         bad_scan;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs === exp_v) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic load_digits(input logic [15:0] d, input logic [3:0] p);
    din   = d;
    dp_in = p;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
  endtask

  // Returns on the negedge where frame_done is high (bounded).
  task automatic wait_fd(input string tag);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 300 && !seen; n++) begin
      @(negedge clk);
      if (frame_done) seen = 1'b1;
    end
    if (!seen) chk({tag, "_fd_timeout"}, 32'd0, 32'd1);
  endtask

  // Called on a frame_done negedge; sample i shows digit i/16, cnt i%16.
  task automatic capture_frame();
    for (int d = 0; d < 4; d++) begin
      on_cnt[d]  = 0;
      seg_cap[d] = '0;
      dp_cap[d]  = 1'b0;
    end
    bad_com  = 0;
    bad_fd   = 0;
    bad_scan = 0;
    @(negedge clk);
    for (int i = 0; i < 64; i++) begin
      int d;
      d = i / 16;
      @(negedge clk);
      if (com != 4'b1111) begin
        on_cnt[d]++;
        if (com != ~(4'b0001 << d)) bad_com++;
      end
      if (i % 16 == 8) begin
        seg_cap[d] = seg;
        dp_cap[d]  = dp;
      end
      if (frame_done !== (i == 62)) bad_fd++;
      if (int'(scan_idx) != ((i + 1) / 16) % 4) bad_scan++;
    end
  endtask

  task automatic check_frame(input string tag, input logic [27:0] exp_seg,
                             input logic [3:0] exp_dp, input int exp_on);
    for (int d = 0; d < 4; d++) begin
      chk($sformatf("%s_seg%0d", tag, d), 32'(seg_cap[d]), 32'(exp_seg[d*7 +: 7]));
      chk($sformatf("%s_dp%0d", tag, d), 32'(dp_cap[d]), 32'(exp_dp[d]));
      chk($sformatf("%s_on%0d", tag, d), on_cnt[d], exp_on);
    end
    chk({tag, "_com_onehot"}, bad_com, 32'd0);
    chk({tag, "_fd_pos"}, bad_fd, 32'd0);
    chk({tag, "_scan"}, bad_scan, 32'd0);
  endtask

  initial begin
    int gap;
    int zeros;
    int early;
    aclr     = 1'b1;
    load     = 1'b0;
    din      = 16'h0000;
    dp_in    = 4'b0000;
    mode     = 1'b1;
    lz_blank = 1'b0;
    bright   = 2'd3;
    lt       = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_com", 32'(com), 32'h0000_000F);
    chk("rst_seg", 32'(seg), 32'd0);
    chk("rst_dp", 32'(dp), 32'd0);
    chk("rst_scan", 32'(scan_idx), 32'd0);
    chk("rst_fd", 32'(frame_done), 32'd0);
    aclr = 1'b0;

    // Basic scan of 1234 at full brightness.
    load_digits(16'h1234, 4'b0000);
    wait_fd("t1");
    capture_frame();
    check_frame("t1", {G1, G2, G3, G4}, 4'b0000, 16);
    wait_fd("t1p");
    gap = 0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      gap++;
      if (frame_done) break;
    end
    chk("t1_fd_period", gap, 32'd64);

    // Two loads inside one frame: only the last appears, and only after frame_done.
    repeat (10) @(negedge clk);
    load_digits(16'h0000, 4'b0000);
    repeat (3) @(negedge clk);
    load_digits(16'h5678, 4'b0000);
    zeros = 0;
    early = 0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (seg == G0) zeros++;
      if (seg == G5 || seg == G6 || seg == G7 || seg == G8) early++;
      if (frame_done) break;
    end
    chk("t2_zero_shown", zeros, 32'd0);
    chk("t2_tearing", early, 32'd0);
    chk("t2_at_fd", 32'(frame_done), 32'd1);
    capture_frame();
    check_frame("t2", {G5, G6, G7, G8}, 4'b0000, 16);

    // BCD invalid codes plus leading-zero blanking, then hex mode.
    mode     = 1'b0;
    lz_blank = 1'b1;
    load_digits(16'h00AF, 4'b0000);
    wait_fd("t3a");
    capture_frame();
    check_frame("t3a", {GX, GX, GX, GX}, 4'b0000, 16);
    mode = 1'b1;
    wait_fd("t3b");
    capture_frame();
    check_frame("t3b", {GX, GX, GA, GF}, 4'b0000, 16);

    // Brightness and lamp test.
    lz_blank = 1'b0;
    bright   = 2'd0;
    load_digits(16'h1234, 4'b0000);
    wait_fd("t4a");
    capture_frame();
    check_frame("t4a", {G1, G2, G3, G4}, 4'b0000, 4);
    bright = 2'd1;
    wait_fd("t4b");
    capture_frame();
    check_frame("t4b", {G1, G2, G3, G4}, 4'b0000, 8);
    bright = 2'd0;
    lt     = 1'b1;
    wait_fd("t4c");
    capture_frame();
    check_frame("t4c", {G8, G8, G8, G8}, 4'b1111, 16);
    lt     = 1'b0;
    bright = 2'd3;

    // All-zero value with blanking; decimal point survives blanking.
    lz_blank = 1'b1;
    load_digits(16'h0000, 4'b0000);
    wait_fd("t5a");
    capture_frame();
    check_frame("t5a", {GX, GX, GX, G0}, 4'b0000, 16);
    load_digits(16'h0000, 4'b0100);
    wait_fd("t5b");
    capture_frame();
    check_frame("t5b", {GX, GX, GX, G0}, 4'b0100, 16);

    // Reset in the middle of digit 2 with a load still pending.
    lz_blank = 1'b0;
    wait_fd("t6");
    repeat (21) @(negedge clk);
    load_digits(16'h1234, 4'b1111);
    repeat (16) @(negedge clk);
    chk("t6_pre_scan", 32'(scan_idx), 32'd2);
    aclr = 1'b1;
    @(negedge clk);
    chk("t6_rst_com", 32'(com), 32'h0000_000F);
    chk("t6_rst_seg", 32'(seg), 32'd0);
    chk("t6_rst_scan", 32'(scan_idx), 32'd0);
    aclr = 1'b0;
    @(negedge clk);
    chk("t6_first_com", 32'(com), 32'h0000_000E);
    chk("t6_first_seg", 32'(seg), 32'(G0));
    gap = 0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      gap++;
      if (frame_done) break;
    end
    chk("t6_fd_gap", gap, 32'd62);
    capture_frame();
    check_frame("t6", {G0, G0, G0, G0}, 4'b0000, 16);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cyq_ssd_scan_ctrl.md
Name: cyq_ssd_scan_ctrl

Overview:
Parametrised multiplexed seven-segment display controller for N common-cathode digits, replacing the fixed 4-digit counter/decoder/BCD-decoder chain. It holds a double-buffered display register and scans one digit per slot with a programmable prescaler. It adds BCD/hex decode, leading-zero blanking, decimal points, PWM brightness and lamp test. It sits between system logic (which loads digit values) and the board COM/segment pins.

Parameters:
DIGITS, 4, number of digits scanned (2..8)
CLK_DIV, 50000, Clk cycles per digit slot; must be a multiple of 2**PWM_BITS
PWM_BITS, 3, brightness resolution
COM_ACT, 0, active level of COM lines (0 = active-low, matching the 138-style select)
SEG_ACT, 1, active level of Seg/Dp lines

Ports:
Clk  in  1  system clock; all logic on rising edge
Aclr  in  1  synchronous, active-high reset
Load  in  1  1-cycle strobe: capture Din/Dp_in into pending buffer
Din  in  4*DIGITS  digit values; nibble k drives digit k; digit 0 is least significant
Dp_in  in  DIGITS  decimal point per digit
Mode  in  1  0 = BCD (10..15 blank), 1 = hex (0..F)
Lz_blank  in  1  1 = blank leading zeros
Bright  in  PWM_BITS  brightness code; 0 = dimmest, all-ones = full
Lt  in  1  lamp test
COM  out  DIGITS  digit enables, one-hot at COM_ACT
Seg  out  7  segments: Seg[6]=a … Seg[0]=g
Dp  out  1  decimal point
Scan_idx  out  $clog2(DIGITS)  index of the digit being driven
Frame_done  out  1  1-cycle pulse on the last cycle of digit DIGITS-1's slot

Behaviour:
- Reset (Aclr=1 at an edge): prescaler=0, Scan_idx=0, pending=active=0, pending_valid=0. COM all inactive; Seg and Dp inactive; Frame_done=0. Aclr has priority over all other inputs.
- Prescaler cnt counts 0..CLK_DIV-1 and wraps. tick = (cnt==CLK_DIV-1).
- On tick, Scan_idx advances and wraps from DIGITS-1 to 0. Frame_done = tick && Scan_idx==DIGITS-1.
- Buffering:
  - Load writes pending and sets pending_valid.
  - On a Frame_done cycle with pending_valid=1, active<=pending and pending_valid is cleared.
  - If Load and Frame_done coincide, active<=Din/Dp_in directly and pending is also updated.
  - Display never changes mid-frame (no tearing).
  - Multiple Loads within one frame: last one wins.
- PWM: slot split into 2**PWM_BITS sub-slots of CLK_DIV>>PWM_BITS cycles. sub = cnt/(CLK_DIV>>PWM_BITS). The selected COM is active iff sub <= Bright; otherwise all COM are inactive. Bright is sampled live.
- Decode of active nibble v for digit Scan_idx:
  - Hex mode glyphs: 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011, A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111.
  - BCD mode: v>=10 gives all segments off.
- Leading-zero blanking: digit k is blanked (Seg off, Dp still shown) iff Lz_blank=1, v_k==0, all higher digits are 0, and k!=0. Digit 0 is never blanked.
- Lamp test: Lt=1 forces Seg=all on and Dp on for the scanned digit, and COM is active for the whole slot (PWM ignored). Scanning continues.
- Output timing: all outputs registered. COM, Seg and Dp reflect (Scan_idx, cnt) from the previous cycle, so latency is 1 cycle; COM and Seg change on the same edge.
- Active levels: outputs are XORed to COM_ACT/SEG_ACT; "inactive" means the non-active level.
- Aclr mid-frame: immediate return to the reset state; the next slot starts at digit 0 with cnt=0.

Decomposition:
- Package cyq_ssd_pkg: 16-entry glyph constant array, BLANK constant, clog2 helper.
- Sub-module cyq_seg_decode: combinational nibble + Mode → 7-bit glyph, including BCD invalid-code blanking.
- Top level holds prescaler, scan counter, buffers, LZ blanking, PWM and output registers.

Test Plan (DIGITS=4, CLK_DIV=16, PWM_BITS=2, COM_ACT=0, SEG_ACT=1):
- Reset, then Load Din=16'h1234, Bright=3 → from the second frame, COM cycles 1110,1101,1011,0111 every 16 clocks; Seg = 0110011, 1111001, 1101101, 0110000; Frame_done pulses every 64 clocks.
- Load 16'h0000 then 16'h5678 mid-frame → display switches only at Frame_done; shows 5678, never 0000.
- Mode=0, Din=16'h00AF, Lz_blank=1 → digits 3,2 blank and digits 1,0 blank (invalid BCD); Mode=1 → digit1=1110111, digit0=1000111, digits 3,2 blank.
- Bright=0 → each COM active for 4 of 16 cycles. Bright=1 → 8 of 16. Lt=1 → 16 of 16 with Seg=1111111 and Dp=1.
- Din=16'h0000, Lz_blank=1 → only digit 0 shows 1111110; Dp_in=4'b0100 → digit 2 shows Dp only.
- Aclr asserted mid-slot of digit 2 → next cycle COM=1111 and Seg=0000000; afterwards scanning restarts at digit 0 with active=0.
